regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-back arbiter and scoreboard for the 32-entry general-purpose register file.
- Shares the register file's single write port between two producers:
  - Port A: ALU path, high priority.
  - Port B: load / multi-cycle unit, low priority.
- Provides a valid/ready handshake on each port.
- Maintains a per-register pending-write busy vector for issue-stage hazard checks.
- Sits between execute/memory stages and the register file write port.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width
NUM_REGS, 32, number of registers tracked by the scoreboard (2**ADDR_W)
STARVE_LIMIT, 4, max consecutive A grants while B waits before B is forced

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
a_valid  input  1  port A write request
a_ready  output  1  port A accepted this cycle
a_addr  input  ADDR_W  port A destination register
a_data  input  DATA_W  port A write data
b_valid  input  1  port B write request
b_ready  output  1  port B accepted this cycle
b_addr  input  ADDR_W  port B destination register
b_data  input  DATA_W  port B write data
rsv_valid  input  1  issue stage reserves a destination register
rsv_addr  input  ADDR_W  register being reserved
busy  output  NUM_REGS  pending-write bit per register, registered
wr_en  output  1  register file write enable, registered
wr_addr  output  ADDR_W  register file write address, registered
wr_data  output  DATA_W  register file write data, registered

Behaviour:
Handshake
- A transfer occurs when valid && ready on a port.
- a_ready / b_ready are combinational from the current valid inputs and the starve counter.
- At most one of a_ready / b_ready is high per cycle.
- A requester must hold addr/data stable while valid is high and ready is low.

Arbitration
- Only A valid -> grant A.
- Only B valid -> grant B.
- Both valid -> grant A, unless starve_cnt == STARVE_LIMIT, then grant B.
- starve_cnt update:
  - +1 when A is granted while B is valid.
  - Cleared to 0 when B is granted or b_valid is low.
  - Saturates at STARVE_LIMIT.

Write path
- Latency 1: a transfer in cycle N gives wr_en=1 with the winner's addr/data in cycle N+1.
- No transfer -> wr_en=0 next cycle; wr_addr/wr_data hold their previous values.
- Transfer with addr 0: handshake completes, wr_en stays 0 (write dropped).

Scoreboard
- rsv_valid && rsv_addr != 0 -> busy[rsv_addr] set at the clock edge.
- A granted transfer to address X -> busy[X] cleared at the same edge as the handshake.
- Set and clear of the same address in the same cycle -> set wins (a newer write is pending).
- busy[0] is always 0.
- A transfer to a non-busy register is legal and leaves busy unchanged.

Reset
- rst=1 at a clock edge forces wr_en=0, wr_addr=0, wr_data=0, busy=0, starve_cnt=0.
- a_ready and b_ready are forced 0 while rst=1.
- A transfer presented during reset is lost.
- Reset mid-operation discards all pending state; no write issues in the cycle after reset.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined:
  - Adds outputs byp_valid (1), byp_addr (ADDR_W), byp_data (DATA_W).
  - These combinationally mirror the winning transfer in its handshake cycle, one cycle before the register file write, so decode can forward.
  - byp_valid=0 for addr-0 transfers and during rst.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then a_valid=1, a_addr=5, a_data=32'hDEADBEEF for one cycle -> a_ready=1 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF; following cycle wr_en=0.
2. rsv_valid=1, rsv_addr=9 -> busy[9]=1. Then b_valid=1, b_addr=9, b_data=32'h1234 -> b_ready=1, busy[9]=0 after that edge, wr_en=1 / wr_addr=9 one cycle later.
3. a_valid and b_valid held high continuously with STARVE_LIMIT=4 -> grant sequence A,A,A,A,B,A,A,A,A,B; wr_addr alternates accordingly.
4. Same cycle: rsv_addr=7 reserved and an A transfer to 7 granted -> busy[7]=1 after the edge. rsv_addr=0 -> busy[0] stays 0.
5. a_valid=1, a_addr=0, a_data=32'hFFFFFFFF -> a_ready=1, wr_en stays 0. With WB_BYPASS_EN defined, byp_valid=0.
6. busy[3]=1 and a transfer pending, assert rst for one cycle -> busy=0, wr_en=0, ready outputs low during reset; the first write after reset appears exactly one cycle after the first post-reset transfer.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Write-back arbiter and pending-write scoreboard for the 32-entry
// general-purpose register file. Two producers share the register file's
// single write port:
//   - Port A: ALU path. It has high priority.
//   - Port B: load / multi-cycle unit. It has low priority.
// Port B is protected from starvation. After STARVE_LIMIT consecutive A grants
// while B is waiting, B is granted.
//
// Optional feature: define WB_BYPASS_EN to add the byp_* outputs. These
// outputs mirror the winning transfer in its handshake cycle, so that decode
// can forward the value one cycle before the register file write.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   a_valid/a_ready        port A handshake (ALU)
//   a_addr/a_data          port A destination register and data
//   b_valid/b_ready        port B handshake (load / multi-cycle)
//   b_addr/b_data          port B destination register and data
//   rsv_valid/rsv_addr     issue stage reserves a destination register
//   busy                   registered pending-write bit per register
//   wr_en/wr_addr/wr_data  registered register file write port
//   byp_valid/byp_addr/byp_data  (WB_BYPASS_EN only) combinational forward
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int NUM_REGS     = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_data,
    input  logic                rsv_valid,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data
`ifdef WB_BYPASS_EN
    ,
    output logic                byp_valid,
    output logic [ADDR_W-1:0]   byp_addr,
    output logic [DATA_W-1:0]   byp_data
`endif
);

    localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]    starve_cnt;
    logic [CNT_W-1:0]    starve_next;
    logic                starve_hit;
    logic                grant_a;
    logic                grant_b;
    logic                xfer;
    logic                wr_fire;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic [NUM_REGS-1:0] busy_next;

    // Arbitration, starve counter and scoreboard next state.
    always_comb begin
        // NOTE: every signal gets a default first. Otherwise a path that does
        // not assign the signal would infer a latch.
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        starve_hit  = (starve_cnt == STARVE_MAX);
        starve_next = starve_cnt;
        busy_next   = busy;

        // Ready is suppressed during reset, so any transfer presented then is lost.
        if (!rst) begin
            if (a_valid && !(b_valid && starve_hit)) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end

        xfer     = grant_a | grant_b;
        win_addr = grant_b ? b_addr : a_addr;
        win_data = grant_b ? b_data : a_data;
        // A transfer to r0 completes the handshake, but the write is dropped.
        wr_fire  = xfer && (win_addr != '0);

        // The counter measures how long B has been waiting behind A.
        if (!b_valid || grant_b) begin
            starve_next = '0;
        end else if (grant_a && !starve_hit) begin
            starve_next = starve_cnt + 1'b1;
        end

        // Clear first, then set. A new reservation in the same cycle is for
        // a newer write, so the set must win.
        if (xfer) begin
            busy_next[win_addr] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

`ifdef WB_BYPASS_EN
    assign byp_valid = wr_fire;
    assign byp_addr  = win_addr;
    assign byp_data  = win_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: busy is reset even though it is a flop array. It is
            // architectural hazard state, and a stale bit would stall issue forever.
            starve_cnt <= '0;
            busy       <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, which keeps the update order irrelevant.
            starve_cnt <= starve_next;
            busy       <= busy_next;
            wr_en      <= wr_fire;
            // Address and data hold their values when there is no write.
            if (wr_fire) begin
                wr_addr <= win_addr;
                wr_data <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Self-checking bench for regfile_wb_arbiter. Directed scenarios are followed
// by randomized traffic. Every cycle is compared against a behavioural model:
// the model tracks the number of consecutive A wins over a waiting B, a busy
// bit array, and the expected register file write.
// Inputs are driven on the falling edge. The ready outputs are sampled 1
// time unit later, and the registered outputs 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int NUM_REGS     = 32;
    localparam int STARVE_LIMIT = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                a_valid, b_valid, rsv_valid;
    logic                a_ready, b_ready;
    logic [ADDR_W-1:0]   a_addr, b_addr, rsv_addr;
    logic [DATA_W-1:0]   a_data, b_data;
    logic [NUM_REGS-1:0] busy;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
`ifdef WB_BYPASS_EN
    logic                byp_valid;
    logic [ADDR_W-1:0]   byp_addr;
    logic [DATA_W-1:0]   byp_data;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .NUM_REGS(NUM_REGS), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef WB_BYPASS_EN
        , .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit              m_busy [NUM_REGS];
    int              m_streak;      // consecutive A wins while B waited
    bit              m_wr_en;
    bit [ADDR_W-1:0] m_wr_addr;
    bit [DATA_W-1:0] m_wr_data;

    function automatic logic [NUM_REGS-1:0] model_busy();
        logic [NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
        m_streak  = 0;
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
    endtask

    task automatic drive(input bit av, input int aa, input int ad,
                         input bit bv, input int ba, input int bd,
                         input bit rv, input int ra, input bit r);
        a_valid = av; a_addr = ADDR_W'(aa); a_data = DATA_W'(ad);
        b_valid = bv; b_addr = ADDR_W'(ba); b_data = DATA_W'(bd);
        rsv_valid = rv; rsv_addr = ADDR_W'(ra); rst = r;
    endtask

    // Runs one cycle with the inputs already driven (just after a falling edge).
    // g returns the grant: 0 = none, 1 = A, 2 = B.
    task automatic step(output int g);
        bit [ADDR_W-1:0] w_addr;
        bit [DATA_W-1:0] w_data;
        #1;
        if (rst)                      g = 0;
        else if (a_valid && b_valid)  g = (m_streak >= STARVE_LIMIT) ? 2 : 1;
        else if (a_valid)             g = 1;
        else if (b_valid)             g = 2;
        else                          g = 0;
        w_addr = (g == 2) ? b_addr : a_addr;
        w_data = (g == 2) ? b_data : a_data;
        check("a_ready", a_ready, g == 1);
        check("b_ready", b_ready, g == 2);
`ifdef WB_BYPASS_EN
        check("byp_valid", byp_valid, g != 0 && w_addr != 0);
        if (g != 0 && w_addr != 0) begin
            check("byp_addr", byp_addr, w_addr);
            check("byp_data", byp_data, w_data);
        end
`endif
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_wr_en = (g != 0) && (w_addr != 0);
            if (m_wr_en) begin
                m_wr_addr = w_addr;
                m_wr_data = w_data;
            end
            if (g != 0) m_busy[w_addr] = 1'b0;
            if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
            m_busy[0] = 1'b0;
            if (g == 1 && b_valid) m_streak = (m_streak < STARVE_LIMIT) ? m_streak + 1 : m_streak;
            else                   m_streak = 0;
        end
        #1;
        check("wr_en",   wr_en,   m_wr_en);
        check("wr_addr", wr_addr, m_wr_addr);
        check("wr_data", wr_data, m_wr_data);
        check("busy",    busy,    model_busy());
        @(negedge clk);
    endtask

    initial begin
        int g;
        bit pa_v, pb_v;
        int pa_addr, pa_data, pb_addr, pb_data;

        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        step(g);
        step(g);
        check("reset_busy", busy, '0);
        check("reset_wr_en", wr_en, 1'b0);

        // 1: a single A write appears one cycle later, then wr_en drops.
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        step(g);
        check("t1_grant", g, 1);
        check("t1_wr_addr", wr_addr, 5);
        check("t1_wr_data", wr_data, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(g);
        check("t1_idle_wr_en", wr_en, 1'b0);

        // 2: reserve r9, then a B write clears it.
        drive(0, 0, 0, 0, 0, 0, 1, 9, 0);
        step(g);
        check("t2_busy9_set", busy[9], 1'b1);
        drive(0, 0, 0, 1, 9, 32'h1234, 0, 0, 0);
        step(g);
        check("t2_grant_b", g, 2);
        check("t2_busy9_clr", busy[9], 1'b0);
        check("t2_wr_addr", wr_addr, 9);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(g);

        // 3: both ports hold valid continuously -> A,A,A,A,B repeating.
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 32'hA0 + i, 1, 2, 32'hB0, 0, 0, 0);
            step(g);
            check("t3_seq", g, (i % 5 == 4) ? 2 : 1);
            check("t3_wr_addr", wr_addr, (i % 5 == 4) ? 2 : 1);
        end

        // 4: a reservation and a write of the same register: the set wins. r0 is never busy.
        drive(1, 7, 32'h77, 0, 0, 0, 1, 7, 0);
        step(g);
        check("t4_busy7_set_wins", busy[7], 1'b1);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(g);
        check("t4_busy0", busy[0], 1'b0);

        // 5: a write to r0 completes the handshake but does not write.
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
        step(g);
        check("t5_grant", g, 1);
        check("t5_wr_en", wr_en, 1'b0);

        // 6: reset while r3 is busy and a transfer is pending.
        drive(0, 0, 0, 0, 0, 0, 1, 3, 0);
        step(g);
        check("t6_busy3", busy[3], 1'b1);
        drive(1, 4, 32'h44, 1, 6, 32'h66, 0, 0, 1);
        step(g);
        check("t6_no_grant", g, 0);
        check("t6_busy_clr", busy, '0);
        check("t6_wr_en", wr_en, 1'b0);
        drive(1, 4, 32'h44, 0, 0, 0, 0, 0, 0);
        step(g);
        check("t6_first_write", wr_en, 1'b1);
        check("t6_first_addr", wr_addr, 4);

        // Randomized traffic. A requester holds its request until it is accepted.
        pa_v = 0; pb_v = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!pa_v && $urandom_range(0, 1) == 1) begin
                pa_v = 1; pa_addr = $urandom_range(0, 31); pa_data = $urandom;
            end
            if (!pb_v && $urandom_range(0, 2) != 0) begin
                pb_v = 1; pb_addr = $urandom_range(0, 31); pb_data = $urandom;
            end
            drive(pa_v, pa_addr, pa_data, pb_v, pb_addr, pb_data,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 31),
                  $urandom_range(0, 63) == 0);
            step(g);
            if (g == 1) pa_v = 0;
            if (g == 2) pb_v = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
